// File: rtl/usf_recovery_param_if.sv
// Sample/result bundle of the unlimited-sampling recovery engine; master drives the strobe and sample.
interface usf_recovery_param_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 24
);
    logic              en;
    logic [DATA_W-1:0] in;
    logic [OUT_W-1:0]  out;
    logic              out_valid;
    logic              primed;
    logic              busy;
    logic              overrun;

    modport master (output en, in, input out, out_valid, primed, busy, overrun);
    modport slave  (input en, in, output out, out_valid, primed, busy, overrun);
endinterface

// File: rtl/usf_recovery_param.sv
// Unlimited-sampling recovery: ORDER-th difference, centred re-fold, ORDER integrations; USF_RECOVERY_SAT_EN clamps sums.
// Latency 2*ORDER+2 clk from the en rising edge; no backpressure -- edges arriving while busy are dropped and set overrun.
module usf_recovery_param #(
    parameter int DATA_W      = 16,
    parameter int ORDER       = 2,
    parameter int LAMBDA_LOG2 = 15,
    parameter int OUT_W       = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    usf_recovery_param_if.slave  bus
);
    localparam int W  = OUT_W + 1;
    localparam int IW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int CW = $clog2(ORDER + 1);
    localparam logic [IW-1:0] LAST = IW'(ORDER - 1);

    typedef enum logic [2:0] {S_IDLE, S_DIFF, S_FOLD, S_INTEG, S_OUT} state_t;

    state_t            r_state;
    logic              r_en_d;
    logic [W-1:0]      r_acc;
    logic [W-1:0]      r_prev [ORDER];
    logic [OUT_W-1:0]  r_intg [ORDER];
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic [OUT_W-1:0]  r_out;
    logic              r_out_valid;
    logic              r_primed;
    logic              r_busy;
    logic              r_overrun;

    logic              w_rise;
    logic [W-1:0]      w_in_ext;
    logic [W-1:0]      w_fold;
    logic [W-1:0]      w_sum;
    logic [CW-1:0]     w_cnt_nxt;

    assign w_rise    = bus.en & ~r_en_d;
    assign w_in_ext  = {{(W-DATA_W){bus.in[DATA_W-1]}}, bus.in};
    // Keeping only LAMBDA_LOG2+1 bits and sign-extending maps the value into [-lambda, lambda).
    assign w_fold    = {{(W-LAMBDA_LOG2-1){r_acc[LAMBDA_LOG2]}}, r_acc[LAMBDA_LOG2:0]};
    assign w_cnt_nxt = (r_cnt == CW'(ORDER)) ? r_cnt : r_cnt + CW'(1);

`ifdef USF_RECOVERY_SAT_EN
    // acc and intg both sit inside the OUT_W range, so the W-bit sum cannot itself overflow.
    logic [W-1:0] w_sum_full;
    assign w_sum_full = r_acc + {r_intg[r_idx][OUT_W-1], r_intg[r_idx]};
    always_comb begin
        w_sum = w_sum_full;
        if (w_sum_full[W-1] != w_sum_full[W-2]) begin
            w_sum = w_sum_full[W-1] ? {2'b11, {(OUT_W-1){1'b0}}}
                                    : {2'b00, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic [OUT_W-1:0] w_sum_wrap;
    assign w_sum_wrap = r_acc[OUT_W-1:0] + r_intg[r_idx];
    assign w_sum      = {w_sum_wrap[OUT_W-1], w_sum_wrap};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_en_d      <= 1'b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                r_prev[k] <= '0;
                r_intg[k] <= '0;
            end
        end else begin
            r_en_d      <= bus.en;
            r_out_valid <= 1'b0;
            // OUT still counts as busy, so an edge coinciding with the return to IDLE is dropped.
            if (w_rise && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_acc   <= w_in_ext;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    r_acc         <= r_acc - r_prev[r_idx];
                    r_prev[r_idx] <= r_acc;
                    if (r_idx == LAST) begin
                        r_state <= S_FOLD;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_FOLD: begin
                    r_acc   <= w_fold;
                    r_idx   <= LAST;
                    r_state <= S_INTEG;
                end
                S_INTEG: begin
                    r_acc         <= w_sum;
                    r_intg[r_idx] <= w_sum[OUT_W-1:0];
                    if (r_idx == '0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                S_OUT: begin
                    // acc already holds an in-range (clamped when enabled) integrator result.
                    r_out       <= r_acc[OUT_W-1:0];
                    r_out_valid <= 1'b1;
                    r_cnt       <= w_cnt_nxt;
                    r_primed    <= (w_cnt_nxt == CW'(ORDER));
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.primed    = r_primed;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
endmodule
